// File: rtl/tea_pkg.sv
// Shared TEA definitions: key-schedule constants, FSM encoding and the round mixing function.
package tea_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned N_ROUNDS     = 32;
  localparam word_t       DELTA        = 32'h9E37_79B9;
  localparam word_t       DEC_SUM_INIT = 32'hC6EF_3720;

  localparam int unsigned CNT_W = $clog2(N_ROUNDS);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST_CNT = cnt_t'(N_ROUNDS - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tea_state_t;

  // One TEA half-round mix term; all arithmetic wraps mod 2^32 and shifts are logical.
  function automatic word_t tea_mix(input word_t v, input word_t ka, input word_t kb,
                                    input word_t sum);
    return ((v << 5'd4) + ka) ^ (v + sum) ^ ((v >> 5'd5) + kb);
  endfunction

endpackage

// File: rtl/tea_dec_round.sv
// One combinational TEA decryption cycle; v1 is updated first and the new v1 feeds the v0 update.
module tea_dec_round
  import tea_pkg::*;
(
  input  word_t v0,
  input  word_t v1,
  input  word_t k0,
  input  word_t k1,
  input  word_t k2,
  input  word_t k3,
  input  word_t sum,
  output word_t v0_next,
  output word_t v1_next
);

  word_t v1_new_s;

  assign v1_new_s = v1 - tea_mix(v0, k2, k3, sum);
  assign v0_next  = v0 - tea_mix(v1_new_s, k0, k1, sum);
  assign v1_next  = v1_new_s;

endmodule

// File: rtl/tiny_decryption_algorithm.sv
// Iterative TEA block decryptor: captures ciphertext and key, runs one TEA cycle per clock,
// and holds the plaintext with ptxt_ready until the requester drops its valids.
module tiny_decryption_algorithm
  import tea_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic          ctxt_valid,
  input  logic [63:0]   ctxt_blk,
  input  logic [127:0]  key,
  output logic [63:0]   ptxt_blk,
  output logic          ptxt_ready
);

  tea_state_t    state_r, state_s;
  cnt_t          cnt_r, cnt_s;
  word_t         sum_r, sum_s;
  word_t         v0_r, v0_s;
  word_t         v1_r, v1_s;
  logic [127:0]  key_r, key_s;
  logic [63:0]   ptxt_blk_r, ptxt_blk_s;
  logic          ptxt_ready_r, ptxt_ready_s;
  word_t         rnd_v0_s, rnd_v1_s;
  logic          req_s;

  assign req_s = key_valid && ctxt_valid;

  tea_dec_round u_round (
    .v0      (v0_r),
    .v1      (v1_r),
    .k0      (key_r[127:96]),
    .k1      (key_r[95:64]),
    .k2      (key_r[63:32]),
    .k3      (key_r[31:0]),
    .sum     (sum_r),
    .v0_next (rnd_v0_s),
    .v1_next (rnd_v1_s)
  );

  // Next-state and datapath-load logic; every register holds unless its state updates it.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    sum_s        = sum_r;
    v0_s         = v0_r;
    v1_s         = v1_r;
    key_s        = key_r;
    ptxt_blk_s   = ptxt_blk_r;
    ptxt_ready_s = ptxt_ready_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          v0_s         = ctxt_blk[63:32];
          v1_s         = ctxt_blk[31:0];
          key_s        = key;
          sum_s        = DEC_SUM_INIT;
          cnt_s        = '0;
          ptxt_ready_s = 1'b0;
          state_s      = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        v0_s  = rnd_v0_s;
        v1_s  = rnd_v1_s;
        sum_s = sum_r - DELTA;
        cnt_s = cnt_r + cnt_t'(32'd1);
        if (cnt_r == LAST_CNT) begin
          ptxt_blk_s   = {rnd_v0_s, rnd_v1_s};
          ptxt_ready_s = 1'b1;
          state_s      = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        // Holding valids keeps the result; a fresh request needs valid low for an edge first.
        if (req_s) begin
          state_s = DONE;
        end else begin
          ptxt_ready_s = 1'b0;
          state_s      = IDLE;
        end
      end
      default: begin
        ptxt_ready_s = 1'b0;
        state_s      = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that discards any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      sum_r        <= 32'h0000_0000;
      v0_r         <= 32'h0000_0000;
      v1_r         <= 32'h0000_0000;
      key_r        <= 128'h0;
      ptxt_blk_r   <= 64'h0;
      ptxt_ready_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      sum_r        <= sum_s;
      v0_r         <= v0_s;
      v1_r         <= v1_s;
      key_r        <= key_s;
      ptxt_blk_r   <= ptxt_blk_s;
      ptxt_ready_r <= ptxt_ready_s;
    end
  end

  assign ptxt_blk   = ptxt_blk_r;
  assign ptxt_ready = ptxt_ready_r;

endmodule

// File: tb/tb_tiny_decryption_algorithm.sv
// Directed and round-trip bench for tiny_decryption_algorithm; ciphertexts come from a
// forward TEA encryption model so expected plaintexts are the original inputs.
module tb_tiny_decryption_algorithm;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_valid;
  logic          ctxt_valid;
  logic [63:0]   ctxt_blk;
  logic [127:0]  key;
  logic [63:0]   ptxt_blk;
  logic          ptxt_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [127:0] key;
    logic [63:0]  ctxt;
    logic [63:0]  ptxt;
    int           hold;
  } vec_t;

  vec_t vecs [4];

  tiny_decryption_algorithm dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .ctxt_valid (ctxt_valid),
    .ctxt_blk   (ctxt_blk),
    .key        (key),
    .ptxt_blk   (ptxt_blk),
    .ptxt_ready (ptxt_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] tea_enc(input logic [127:0] k, input logic [63:0] pt);
    logic [31:0] v0, v1, s;
    v0 = pt[63:32];
    v1 = pt[31:0];
    s  = 32'h0;
    for (int r = 0; r < 32; r++) begin
      s  = s + 32'h9E3779B9;
      v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
      v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
    end
    return {v0, v1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, optionally perturb inputs mid-run, check latency, result, hold and release.
  task automatic run_req(input string name, input logic [127:0] k, input logic [63:0] c,
                         input logic [63:0] exp, input int perturb_at, input int hold);
    int n;
    logic got;
    logic hold_ok;
    @(negedge clk);
    key        = k;
    ctxt_blk   = c;
    key_valid  = 1'b1;
    ctxt_valid = 1'b1;
    @(posedge clk);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (ptxt_ready) got = 1'b1;
      else if (n == perturb_at) begin
        key      = ~k;
        ctxt_blk = c ^ 64'hDEAD_BEEF_0BAD_F00D;
      end
    end
    check({name, " latency"}, 64'(n), 64'd32);
    check({name, " ready"}, {63'd0, got}, 64'd1);
    check({name, " ptxt"}, ptxt_blk, exp);
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (ptxt_ready !== 1'b1 || ptxt_blk !== exp) hold_ok = 1'b0;
    end
    if (hold > 0) check({name, " hold"}, {63'd0, hold_ok}, 64'd1);
    @(negedge clk);
    key_valid  = 1'b0;
    ctxt_valid = 1'b0;
    @(posedge clk);
    #1;
    check({name, " release ready"}, {63'd0, ptxt_ready}, 64'd0);
    check({name, " keep ptxt"}, ptxt_blk, exp);
  endtask

  initial begin
    logic [127:0] rk;
    logic [63:0]  rp;
    logic         idle_ok;

    rst        = 1'b1;
    key_valid  = 1'b0;
    ctxt_valid = 1'b0;
    ctxt_blk   = 64'h0;
    key        = 128'h0;

    vecs[0] = '{key: 128'h0, ctxt: 64'h41EA3A0A94BAA940, ptxt: 64'h0, hold: 10};
    vecs[1].key  = 128'h0123456789ABCDEFFEDCBA9876543210;
    vecs[1].ptxt = 64'h0123456789ABCDEF;
    vecs[1].hold = 0;
    vecs[2].key  = {128{1'b1}};
    vecs[2].ptxt = {64{1'b1}};
    vecs[2].hold = 2;
    vecs[3].key  = 128'h0;
    vecs[3].ptxt = 64'h0000000100000000;
    vecs[3].hold = 0;
    for (int i = 1; i < 4; i++) vecs[i].ctxt = tea_enc(vecs[i].key, vecs[i].ptxt);

    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {63'd0, ptxt_ready}, 64'd0);
    check("reset ptxt", ptxt_blk, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      run_req($sformatf("vec%0d", i), vecs[i].key, vecs[i].ctxt, vecs[i].ptxt, -1, vecs[i].hold);

    // Reset during RUN discards the operation and clears the result.
    @(negedge clk);
    key        = vecs[1].key;
    ctxt_blk   = vecs[1].ctxt;
    key_valid  = 1'b1;
    ctxt_valid = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrun reset ready", {63'd0, ptxt_ready}, 64'd0);
    check("midrun reset ptxt", ptxt_blk, 64'h0);
    @(negedge clk);
    rst        = 1'b0;
    key_valid  = 1'b0;
    ctxt_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("post reset idle", {63'd0, ptxt_ready}, 64'd0);
    run_req("after reset", vecs[0].key, vecs[0].ctxt, 64'h0, -1, 0);

    run_req("perturb", vecs[0].key, vecs[0].ctxt, 64'h0, 10, 0);

    // Only ctxt_valid high must never start a run.
    @(negedge clk);
    key        = vecs[1].key;
    ctxt_blk   = vecs[1].ctxt;
    ctxt_valid = 1'b1;
    idle_ok    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (ptxt_ready !== 1'b0) idle_ok = 1'b0;
    end
    check("partial valid idle", {63'd0, idle_ok}, 64'd1);
    run_req("partial then full", vecs[1].key, vecs[1].ctxt, vecs[1].ptxt, -1, 0);

    for (int i = 0; i < 200; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom};
      if (i == 0) begin
        rk = {128{1'b1}};
        rp = {64{1'b1}};
      end else if (i == 1) begin
        rk = {128{1'b1}};
        rp = 64'h0;
      end else if (i == 2) begin
        rk = 128'h0;
        rp = {64{1'b1}};
      end
      run_req($sformatf("rt%0d", i), rk, tea_enc(rk, rp), rp, -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tiny_decryption_algorithm.md
Name: tiny_decryption_algorithm

Overview:
Iterative TEA block decryptor; the inverse of tiny_encryption_algorithm, using the same valid/ready handshake style.
- Takes a 64-bit ciphertext block and a 128-bit key, and runs 32 TEA cycles, one cycle per clock, with decrementing sum.
- Returns the 64-bit plaintext.
- Sits beside the encryptor, on the receive side of the link; the two can be chained for round-trip checking.

Parameters:
N_ROUNDS, 32, number of TEA cycles, each covering both half-updates.
DELTA, 32'h9E3779B9, TEA key-schedule constant.

Ports:
clk  input  1  single clock; everything is updated on the rising edge.
rst  input  1  synchronous active-high reset.
key_valid  input  1  key stable and valid.
ctxt_valid  input  1  ciphertext stable and valid.
ctxt_blk  input  64  ciphertext; v0=[63:32], v1=[31:0].
key  input  128  key; k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0].
ptxt_blk  output  64  plaintext; v0=[63:32], v1=[31:0].
ptxt_ready  output  1  1 = ptxt_blk stable and valid.

Behaviour:
- Reset: rst=1 at an edge gives state=IDLE, ptxt_ready=0, ptxt_blk=0, round counter=0, sum=0, v0=v1=0, key regs=0. Reset dominates every other event, including mid-RUN and in DONE; the operation in progress is discarded.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - If key_valid && ctxt_valid at edge t0: latch v0, v1, k0..k3; set sum=N_ROUNDS*DELTA mod 2^32 (32'hC6EF3720); set cnt=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, at each edge (all arithmetic is mod 2^32; shifts are logical; the new v1 is used for the v0 update):
  - v1 <= v1 - (((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)).
  - v0 <= v0 - (((v1'<<4)+k0) ^ (v1'+sum) ^ ((v1'>>5)+k1)), where v1' is the new v1 from the line above.
  - sum <= sum - DELTA; cnt <= cnt+1.
  - When cnt==N_ROUNDS-1, that edge also loads ptxt_blk <= {v0', v1'} and sets ptxt_ready=1; go to DONE.
  - Rounds occupy edges t0+1..t0+32; ptxt_ready is first high after edge t0+32.
- Inputs are ignored during RUN: the latched copies are used, so changes on ctxt_blk or key mid-operation have no effect.
- DONE:
  - ptxt_ready=1 and ptxt_blk is held constant.
  - Stay in DONE while key_valid && ctxt_valid.
  - When either valid is low at an edge: ptxt_ready <= 0, go to IDLE.
  - A new request therefore needs valid to drop for at least one edge. This prevents one request from being decrypted twice.
- ptxt_blk keeps its last result after ptxt_ready falls, until the next completion or reset.
- Valid asserted in the same cycle that reset is released: reset wins at that edge; the request is captured at the first edge with rst=0.
- Only one of key_valid or ctxt_valid high: no capture.

Decomposition:
- Package tea_pkg:
  - DELTA, N_ROUNDS, DEC_SUM_INIT (32'hC6EF3720).
  - typedef tea_state_t enum {IDLE, RUN, DONE}.
  - typedef word_t logic[31:0].
  - The encryptor shares this package.
- Sub-module tea_dec_round: purely combinational, one TEA decryption cycle.
  - Inputs: v0, v1, k0..k3, sum.
  - Outputs: v0', v1'.
  - The top level holds the FSM, the counter and the registers.

Test Plan:
- Known vector: key=0, ctxt=64'h41EA3A0A94BAA940 -> ptxt_blk=64'h0000000000000000; ptxt_ready rises exactly 32 edges after the capture edge.
- Handshake hold: keep the valids high for 10 cycles after ready -> ptxt_ready and ptxt_blk stay stable, with no re-capture. Drop the valids -> ptxt_ready=0 at the next edge, state=IDLE.
- Input change mid-RUN: alter ctxt_blk and key at round 10 -> the result still equals the decryption of the captured values (known vector gives 0).
- Reset mid-RUN: assert rst at round 15 -> next edge gives ptxt_ready=0, ptxt_blk=0. A new known-vector request afterwards completes correctly.
- Round-trip: chain tiny_encryption_algorithm into this block with 200 random key/plaintext pairs -> recovered ptxt equals the original every time. Include key=128'hFFFF...FF and pt=64'hFFFF...FF so the wrap-around of the mod 2^32 arithmetic is exercised.
- Partial valid: ctxt_valid=1, key_valid=0 for 50 cycles -> stays in IDLE with ptxt_ready=0. Then raise key_valid -> capture at that edge.
